// File: rtl/vga_ctrl_param_if.sv
// rtl/vga_ctrl_param_if.sv - pixel request / video output bundle for vga_ctrl_param
interface vga_ctrl_param_if #(
    parameter int RGB_W = 16
);
    // look-ahead request to the pixel generator and its returned data
    logic             pix_req;
    logic [10:0]      pix_x;
    logic [10:0]      pix_y;
    logic [RGB_W-1:0] pix_data;

    // registered video outputs towards the DAC pins
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             frame_start;
    logic             line_start;
    logic [RGB_W-1:0] rgb;

    modport master (
        output pix_req, pix_x, pix_y,
        output hsync, vsync, de, frame_start, line_start, rgb,
        input  pix_data
    );

    modport slave (
        input  pix_req, pix_x, pix_y,
        input  hsync, vsync, de, frame_start, line_start, rgb,
        output pix_data
    );
endinterface

// File: rtl/vga_ctrl_param.sv
// rtl/vga_ctrl_param.sv - parametrised VGA timing with look-ahead pixel request (optional colorbar: VGA_CTRL_TEST_PATTERN_EN)
module vga_ctrl_param #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int RGB_W    = 16,
    parameter int REQ_LEAD = 1
) (
    input  logic            vga_clk,
    input  logic            sys_rst_n,
`ifdef VGA_CTRL_TEST_PATTERN_EN
    input  logic            test_en,
`endif
    vga_ctrl_param_if.master vif
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HA0     = H_SYNC + H_BACK;
    localparam int VA0     = V_SYNC + V_BACK;

    // one extra count of headroom so HA0+H_ACTIVE fits even with no front porch
    localparam int HCW = $clog2(H_TOTAL + 1);
    localparam int VCW = $clog2(V_TOTAL + 1);

    localparam logic [HCW-1:0] H_LAST  = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST  = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0] H_SYNC_C = HCW'(H_SYNC);
    localparam logic [VCW-1:0] V_SYNC_C = VCW'(V_SYNC);
    localparam logic [HCW-1:0] HA_BEG  = HCW'(HA0);
    localparam logic [HCW-1:0] HA_END  = HCW'(HA0 + H_ACTIVE);
    localparam logic [VCW-1:0] VA_BEG  = VCW'(VA0);
    localparam logic [VCW-1:0] VA_END  = VCW'(VA0 + V_ACTIVE);
    localparam logic [HCW-1:0] REQ_BEG = HCW'(HA0 - REQ_LEAD);
    localparam logic [HCW-1:0] REQ_END = HCW'(HA0 + H_ACTIVE - REQ_LEAD);

    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    // reject lead times the back porch cannot hide or the generator cannot have
    if (REQ_LEAD > 4 || REQ_LEAD < 0 || H_SYNC + H_BACK < REQ_LEAD) begin : g_bad_req_lead
        $error("vga_ctrl_param: REQ_LEAD must be 0..4 and not exceed H_SYNC+H_BACK");
    end

    logic [HCW-1:0]   h_cnt;
    logic [VCW-1:0]   v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             hs_c;
    logic             vs_c;
    logic             h_act;
    logic             v_act;
    logic             act_c;
    logic             req_c;
    logic [RGB_W-1:0] pix_sel;

    // free-running raster counters; vertical steps on horizontal wrap
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // raw timing decode straight off the counters
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        hs_c   = (h_cnt < H_SYNC_C);
        vs_c   = (v_cnt < V_SYNC_C);
        h_act  = (h_cnt >= HA_BEG) && (h_cnt < HA_END);
        v_act  = (v_cnt >= VA_BEG) && (v_cnt < VA_END);
        act_c  = h_act && v_act;
        // request window is the active window shifted earlier by the generator latency
        req_c  = sys_rst_n && v_act && (h_cnt >= REQ_BEG) && (h_cnt < REQ_END);
    end

    // look-ahead pixel request; coordinates idle at all-ones outside the window
    always_comb begin
        vif.pix_req = req_c;
        vif.pix_x   = '1;
        vif.pix_y   = '1;
        if (req_c) begin
            vif.pix_x = 11'(h_cnt - REQ_BEG);
            vif.pix_y = 11'(v_cnt - VA_BEG);
        end
    end

`ifdef VGA_CTRL_TEST_PATTERN_EN
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int BCW    = $clog2(BAR_W + 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);
    localparam int R_W    = RGB_W / 3;
    localparam int B_W    = RGB_W / 3;
    localparam int G_W    = RGB_W - R_W - B_W;

    logic             tp_en;
    logic [BCW-1:0]   bar_pix;
    logic [2:0]       bar_idx;
    logic             bar_r;
    logic             bar_g;
    logic             bar_b;
    logic [RGB_W-1:0] bar_rgb;

    // pattern enable only changes on the frame boundary so a frame is never torn
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            tp_en <= 1'b0;
        end else if (h_cnt == '0 && v_cnt == '0) begin
            tp_en <= test_en;
        end
    end

    // bar position tracks the current h_cnt; held at bar 0 outside the active span
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n || !h_act) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (bar_pix == BAR_LAST) begin
            bar_pix <= '0;
            if (bar_idx != 3'd7) begin
                bar_idx <= bar_idx + 3'd1;
            end
        end else begin
            bar_pix <= bar_pix + 1'b1;
        end
    end

    // white, yellow, cyan, green, magenta, red, blue, black
    always_comb begin
        bar_r   = ~bar_idx[1];
        bar_g   = ~bar_idx[2];
        bar_b   = ~bar_idx[0];
        bar_rgb = {{R_W{bar_r}}, {G_W{bar_g}}, {B_W{bar_b}}};
    end

    // choose between the external generator and the internal colorbar
    always_comb begin
        pix_sel = vif.pix_data;
        if (tp_en) begin
            pix_sel = bar_rgb;
        end
    end
`else
    // only the external generator feeds the pixel path
    always_comb begin
        pix_sel = vif.pix_data;
    end
`endif

    // output stage: one clock behind the counters so returned pixels meet de
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            vif.hsync       <= ~HS_ON;
            vif.vsync       <= ~VS_ON;
            vif.de          <= 1'b0;
            vif.rgb         <= '0;
            vif.frame_start <= 1'b0;
            vif.line_start  <= 1'b0;
        end else begin
            vif.hsync       <= hs_c ? HS_ON : ~HS_ON;
            vif.vsync       <= vs_c ? VS_ON : ~VS_ON;
            vif.de          <= act_c;
            vif.rgb         <= act_c ? pix_sel : '0;
            vif.frame_start <= (h_cnt == '0) && (v_cnt == '0);
            vif.line_start  <= (h_cnt == '0);
        end
    end
endmodule

// File: doc/vga_ctrl_param.md
Name: vga_ctrl_param

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates H/V timing from parameters and issues a look-ahead pixel request (pix_req, pix_x, pix_y) to a pixel generator of fixed latency REQ_LEAD.
- Registers hsync/vsync/de/rgb so the returned pixel data lands aligned with the active window.
- Sits between the clock divider and the resistor-network DAC pins.

Parameters:
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- RGB_W, 16, pixel width (RGB565 default)
- REQ_LEAD, 1, pixel generator latency in clocks, 0..4; requires H_SYNC+H_BACK >= REQ_LEAD

Ports:
- vga_clk  in  1  pixel clock
- sys_rst_n  in  1  synchronous active-low reset
- pix_data  in  RGB_W  pixel from generator, valid REQ_LEAD clocks after matching pix_req
- pix_req  out  1  request for pixel (pix_x, pix_y)
- pix_x  out  11  requested column 0..H_ACTIVE-1, all-ones when pix_req=0
- pix_y  out  11  requested row 0..V_ACTIVE-1, all-ones when pix_req=0
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  display enable (rgb valid)
- frame_start  out  1  one-clock pulse at start of frame
- line_start  out  1  one-clock pulse at start of each line
- rgb  out  RGB_W  pixel to DAC, zero outside active window

Behaviour:
- Reset is synchronous: on a rising edge of vga_clk with sys_rst_n=0:
  - h_cnt=0, v_cnt=0
  - hsync=~HS_POL, vsync=~VS_POL
  - de=0, rgb=0, frame_start=0, line_start=0, pix_req=0
  - pix_x and pix_y all-ones
- Reset mid-frame aborts the frame. The first clock after release has h_cnt=0, v_cnt=0.
- Counters:
  - H_TOTAL = sum of the four H params; V_TOTAL likewise.
  - h_cnt increments every clock and wraps H_TOTAL-1 -> 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps V_TOTAL-1 -> 0 on the same edge.
- Line order: sync, back porch, active, front porch.
  - Active H: h_cnt in [HA0, HA0+H_ACTIVE), where HA0 = H_SYNC+H_BACK.
  - Active V: v_cnt in [VA0, VA0+V_ACTIVE), where VA0 = V_SYNC+V_BACK.
- Combinational timing from counters:
  - hs_c = (h_cnt < H_SYNC)
  - vs_c = (v_cnt < V_SYNC)
  - act_c = H-active & V-active
- Request:
  - pix_req = V-active & h_cnt in [HA0-REQ_LEAD, HA0+H_ACTIVE-REQ_LEAD).
  - pix_x = h_cnt-(HA0-REQ_LEAD); pix_y = v_cnt-VA0.
  - These are combinational from the counter registers.
- Output stage, registered, one clock latency from counters:
  - hsync <= hs_c ? HS_POL : ~HS_POL; vsync likewise with VS_POL.
  - de <= act_c.
  - rgb <= act_c ? pix_data : 0.
  - frame_start <= (h_cnt==0 & v_cnt==0).
  - line_start <= (h_cnt==0).
- Alignment: pixel requested at clock t is sampled at t+REQ_LEAD and appears on rgb at t+REQ_LEAD+1, together with de=1.
- REQ_LEAD=0: pix_req coincides with act_c; the generator must be combinational.
- Parameter check: an elaboration error when H_SYNC+H_BACK < REQ_LEAD or REQ_LEAD > 4.

Optional Feature:
- Macro VGA_CTRL_TEST_PATTERN_EN.
- Defined:
  - Adds input test_en (1 bit).
  - When test_en=1, rgb in the active window comes from an internal 8-bar colorbar instead of pix_data.
  - Bar index = (h_cnt-HA0)*8/H_ACTIVE, computed with a bar counter that advances every H_ACTIVE/8 active pixels.
  - Bars in order: white, yellow, cyan, green, magenta, red, blue, black. Components are full-scale for the RGB_W split; for RGB_W=16, white=FFFF and red=F800.
  - pix_req still toggles as normal.
  - test_en is sampled only at frame_start; it never changes mid-frame.
- Undefined: no test_en port; rgb always comes from pix_data.

Test Plan:
- Defaults, free-run two frames -> hsync low exactly 96 of every 800 clocks; vsync low exactly 1600 clocks per 420000; frame_start period 420000; line_start period 800.
- Defaults, REQ_LEAD=1, generator echoes {pix_y[4:0],pix_x[10:0]} -> first pix_req at h_cnt=143,v_cnt=35 with pix_x=0,pix_y=0; de rises at registered h_cnt=144; rgb first value 0x0000, then 0x0001, consecutive, no gaps.
- Small timing H 4/4/8/4, V 1/1/4/1, REQ_LEAD=3 -> 8 de clocks per line, 4 lines per frame; rgb equals request issued 4 clocks earlier; rgb=0 whenever de=0.
- HS_POL=1, VS_POL=1 -> sync pulses active-high with the same widths; idle level 0 after reset.
- Reset asserted mid-active-line for 3 clocks -> during reset all outputs at reset values (hsync=~HS_POL, rgb=0, pix_x=7FF); first clock after release hs_c active; frame_start pulses 1 clock later.
- With VGA_CTRL_TEST_PATTERN_EN, defaults, test_en=1 -> active pixels 0..79 = FFFF, 80..159 = FFE0, 400..479 = F800, 560..639 = 0000; test_en toggled mid-frame has no effect until the next frame_start.
